radix8_result_writeback: RTL and testbench
==========================================

Name: radix8_result_writeback

Overview:
- Consumer end of the radix-8 butterfly output interface.
- Accepts one 8-word result bundle per handshake from the radix-8 butterfly datapath and buffers it in a 2-entry ping-pong store.
- Serialises each bundle to a single-port coefficient memory write interface, one word per accepted write, with stride-based address generation.
- Sits between the butterfly core and the coefficient RAM in the NTT/INTT stage loop.

Parameters:
- width, 16, coefficient word width in bits.
- addr_width, 10, coefficient memory address width.
- Q, 7681, modulus; used only by the optional scaler.
- N_INV, 7651, n^-1 mod Q for n=256; used only by the optional scaler.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bundle valid.
- in_ready  out  1  bundle can be accepted.
- in_data  in  8*width  word k (k=0..7) at bits [k*width +: width]; word 0 is butterfly output_1.
- in_base_addr  in  addr_width  memory address of word 0.
- in_stride  in  addr_width  address step between consecutive words.
- in_select  in  1  0 = NTT bundle, 1 = INTT bundle.
- wr_en  out  1  write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  addr_width  write address.
- wr_data  out  width  write data.
- bundle_done  out  1  one-cycle pulse when word 7 of a bundle is written.
- busy  out  1  buffer non-empty or drain in progress.
- bundle_count  out  16  bundles fully written since reset; wraps at 65535 -> 0.

Behaviour:
- Reset (async assert, sync release): buffer empty, state IDLE, word counter 0, in_ready=0 while rst_n=0. On the first cycle after release: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, bundle_done=0, busy=0, bundle_count=0.
- Input handshake:
  - Bundle accepted on a rising edge with in_valid && in_ready.
  - in_data, in_base_addr, in_stride and in_select are captured into the write-pointer entry; the write pointer then toggles.
  - in_ready = (occupancy < 2), driven from registers only. There is no combinational path from wr_ready or in_valid.
- FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when occupancy becomes non-zero. Registered: first wr_en is asserted the cycle after acceptance (latency 1).
  - DRAIN: wr_en=1. Word counter k (3 bits) selects the word from the read-pointer entry.
    - wr_addr = (base + k*stride) mod 2^addr_width; wraps silently.
    - wr_data = word k.
  - k increments only on wr_en && wr_ready. While wr_ready=0, wr_addr and wr_data are held stable.
  - On the handshake at k=7:
    - bundle_done pulses for one cycle.
    - bundle_count increments.
    - The entry is freed and the read pointer toggles.
    - k resets to 0.
    - If occupancy is still non-zero, stay in DRAIN with no bubble cycle; otherwise go to IDLE.
- Simultaneous accept and free in the same cycle: occupancy unchanged. in_ready is not raised in the same cycle a full buffer frees; it rises the following cycle.
- busy = (occupancy != 0).
- in_stride = 0 is legal: all 8 writes go to in_base_addr, in order.
- in_select has no effect on data unless the optional feature is compiled in.
- rst_n asserted mid-drain: the bundle is discarded and wr_en drops immediately (async). There is no partial-bundle recovery.

Optional Feature:
- Macro: RADIX8_WB_INTT_SCALE_EN.
- Defined:
  - For entries captured with in_select=1, wr_data = (word k * N_INV) mod Q, computed combinationally from the buffered word.
  - The product is 2*width bits wide before reduction.
  - NTT entries pass through unchanged.
  - Latency is unchanged.
- Undefined: wr_data is always the raw word; Q and N_INV are unused.

Test Plan:
- Single bundle: words 1..8, base=0x010, stride=0x020, wr_ready=1 -> writes on cycles t+1..t+8 to 0x010,0x030,...,0x0F0 with data 1..8; bundle_done pulses on the 8th write; bundle_count=1; busy=0 afterwards.
- Backpressure: wr_ready low on cycles 3-5 of the drain -> wr_addr and wr_data held for those cycles; 8 writes total, in order, none duplicated.
- Buffer full: three back-to-back bundles with wr_ready=0 -> first two accepted; in_ready=0 on the third; the third is accepted one cycle after the first bundle's 8th write; 24 writes total with no bubble between bundles.
- Address wrap: base=0x3F8, stride=0x002 -> addresses 0x3F8,0x3FA,0x3FC,0x3FE,0x000,0x002,0x004,0x006.
- Reset during the 4th write -> wr_en=0 immediately; after release in_ready=1, bundle_count=0, no further writes.
- With RADIX8_WB_INTT_SCALE_EN and in_select=1, word=2 -> wr_data=(2*7651) mod 7681=7621; with in_select=0, wr_data=2.

Source files
------------

// File: rtl/radix8_result_writeback_if.sv
// Butterfly-bundle input and coefficient-memory write port bundle for radix8_result_writeback.
// slave is the writeback block's view; master is the producer/memory side.
interface radix8_result_writeback_if #(
  parameter int unsigned Width     = 16,
  parameter int unsigned AddrWidth = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*Width-1:0]     in_data;
  logic [AddrWidth-1:0]   in_base_addr;
  logic [AddrWidth-1:0]   in_stride;
  logic                   in_select;
  logic                   wr_en;
  logic                   wr_ready;
  logic [AddrWidth-1:0]   wr_addr;
  logic [Width-1:0]       wr_data;
  logic                   bundle_done;
  logic                   busy;
  logic [15:0]            bundle_count;

  modport master (
    output in_valid, in_data, in_base_addr, in_stride, in_select, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, bundle_done, busy, bundle_count
  );

  modport slave (
    input  in_valid, in_data, in_base_addr, in_stride, in_select, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, bundle_done, busy, bundle_count
  );
endinterface

// File: rtl/radix8_result_writeback.sv
// Buffers 8-word radix-8 butterfly bundles in a 2-entry ping-pong store and drains them
// word by word to a coefficient RAM. Optional INTT n^-1 scaling: RADIX8_WB_INTT_SCALE_EN.
module radix8_result_writeback #(
  parameter int unsigned Width     = 16,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned Q         = 7681,
  parameter int unsigned NInv      = 7651
) (
  input logic                      clk,
  input logic                      rst_n,
  radix8_result_writeback_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                 state_q;
  logic [1:0]             occ_q, occ_d;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [2:0]             k_q;
  logic                   in_ready_q;
  logic                   done_q;
  logic [15:0]            count_q;
  logic [8*Width-1:0]     data_q   [2];
  logic [AddrWidth-1:0]   base_q   [2];
  logic [AddrWidth-1:0]   stride_q [2];
  logic                   sel_q    [2];

  logic                   accept;
  logic                   wr_fire;
  logic                   last_fire;
  logic                   draining;
  logic [Width-1:0]       word;
  logic [Width-1:0]       out_data;

  always_comb begin
    draining  = (state_q == StDrain);
    accept    = bus.in_valid && in_ready_q;
    wr_fire   = draining && bus.wr_ready;
    last_fire = wr_fire && (k_q == 3'd7);
    occ_d     = occ_q;
    if (accept && !last_fire) begin
      occ_d = occ_q + 2'd1;
    end else if (!accept && last_fire) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      k_q         <= 3'd0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 16'd0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      base_q[0]   <= '0;
      base_q[1]   <= '0;
      stride_q[0] <= '0;
      stride_q[1] <= '0;
      sel_q[0]    <= 1'b0;
      sel_q[1]    <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      // Registered from next occupancy, so a freeing full buffer raises in_ready a cycle later.
      in_ready_q <= (occ_d < 2'd2);
      done_q     <= last_fire;
      if (accept) begin
        data_q[wr_ptr_q]   <= bus.in_data;
        base_q[wr_ptr_q]   <= bus.in_base_addr;
        stride_q[wr_ptr_q] <= bus.in_stride;
        sel_q[wr_ptr_q]    <= bus.in_select;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      // 3-bit counter wraps 7 -> 0 on the final word of a bundle.
      if (wr_fire) begin
        k_q <= k_q + 3'd1;
      end
      if (last_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + 16'd1;
      end
      unique case (state_q)
        StIdle:  if (occ_d != 2'd0) state_q <= StDrain;
        StDrain: if (last_fire && (occ_d == 2'd0)) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    word = data_q[rd_ptr_q][32'(k_q)*Width +: Width];
  end

`ifdef RADIX8_WB_INTT_SCALE_EN
  logic [2*Width-1:0] prod;
  logic [Width-1:0]   scaled;

  always_comb begin
    prod     = {{Width{1'b0}}, word} * (2*Width)'(NInv);
    scaled   = Width'(prod % (2*Width)'(Q));
    out_data = sel_q[rd_ptr_q] ? scaled : word;
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{32'(Q), 32'(NInv), sel_q[0], sel_q[1]};

  always_comb begin
    out_data = word;
  end
`endif

  always_comb begin
    bus.in_ready     = in_ready_q;
    bus.wr_en        = draining;
    bus.wr_addr      = draining ? base_q[rd_ptr_q] + AddrWidth'(k_q) * stride_q[rd_ptr_q] : '0;
    bus.wr_data      = draining ? out_data : '0;
    bus.bundle_done  = done_q;
    bus.busy         = (occ_q != 2'd0);
    bus.bundle_count = count_q;
  end

endmodule

// File: tb/tb_radix8_result_writeback.sv
// Scoreboard bench for radix8_result_writeback: directed bundles push expected writes,
// a negedge monitor pops and checks every accepted memory write and bundle_done timing.
module tb_radix8_result_writeback;
  localparam int W  = 16;
  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   pop_cnt;
  int   last_pop_cyc;
  int   done_cyc [$];
  exp_t sb_q [$];
  logic prev_last;
  logic mon_last;
  exp_t mon_e;

  radix8_result_writeback_if #(.Width(W), .AddrWidth(AW)) bus ();

  radix8_result_writeback #(.Width(W), .AddrWidth(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted write must match the scoreboard head; bundle_done must follow
  // the cycle after the 8th word of a bundle is accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      mon_last = 1'b0;
      if (bus.bundle_done || prev_last) chk("bundle_done", 32'(bus.bundle_done), 32'(prev_last));
      if (bus.wr_en && bus.wr_ready) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.wr_addr, bus.wr_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
          mon_last = mon_e.last;
          if (mon_e.last) done_cyc.push_back(cyc);
        end
      end
      prev_last = mon_last;
    end
  end

  // Called and returns at posedge+1; returns in the first cycle after acceptance.
  task automatic send(input logic [AW-1:0] base, input logic [AW-1:0] stride, input logic sel,
                      input logic [8*W-1:0] data, input logic [8*AW-1:0] ea,
                      input logic [8*W-1:0] ed);
    exp_t e;
    int   n;
    for (int k = 0; k < 8; k++) begin
      e.addr = ea[k*AW +: AW];
      e.data = ed[k*W +: W];
      e.last = (k == 7);
      sb_q.push_back(e);
    end
    bus.in_valid     = 1'b1;
    bus.in_data      = data;
    bus.in_base_addr = base;
    bus.in_stride    = stride;
    bus.in_select    = sel;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.in_ready) begin
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (bus.busy) begin
      bad++;
      $display("FAIL drain_timeout: got busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   p_done;
    int   p_pop;
    int   acc_c;
    int   x;
    logic [8*W-1:0] scale_exp;

    total = 0; bad = 0; cyc = 0; pop_cnt = 0; last_pop_cyc = 0; prev_last = 1'b0;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_base_addr = '0;
    bus.in_stride    = '0;
    bus.in_select    = 1'b0;
    bus.wr_ready     = 1'b1;

    // Reset
    #12;
    chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    chk("wr_en_in_reset", 32'(bus.wr_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_bundle_done", 32'(bus.bundle_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bundle_count", 32'(bus.bundle_count), 32'd0);

    // Single bundle
    send(10'h010, 10'h020, 1'b0,
         {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
         {10'h0F0, 10'h0D0, 10'h0B0, 10'h090, 10'h070, 10'h050, 10'h030, 10'h010},
         {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    chk("latency_wr_en", 32'(bus.wr_en), 32'd1);
    chk("latency_wr_addr", 32'(bus.wr_addr), 32'h010);
    chk("single_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    chk("single_count", 32'(bus.bundle_count), 32'd1);
    chk("single_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure on drain cycles 3-5
    p_pop = pop_cnt;
    send(10'h100, 10'h001, 1'b0,
         {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
         {10'h107, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 10'h100},
         {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wr_ready = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      chk("bp_hold_addr", 32'(bus.wr_addr), 32'h102);
      chk("bp_hold_data", 32'(bus.wr_data), 32'h3333);
      chk("bp_hold_wr_en", 32'(bus.wr_en), 32'd1);
      @(posedge clk); #1;
    end
    bus.wr_ready = 1'b1;
    wait_idle();
    chk("bp_write_count", 32'(pop_cnt - p_pop), 32'd8);
    chk("bp_count", 32'(bus.bundle_count), 32'd2);

    // Buffer full: three bundles with memory stalled
    bus.wr_ready = 1'b0;
    p_pop = pop_cnt;
    send(10'h000, 10'h008, 1'b0,
         {16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000},
         {10'h038, 10'h030, 10'h028, 10'h020, 10'h018, 10'h010, 10'h008, 10'h000},
         {16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000});
    send(10'h200, 10'h004, 1'b0,
         {16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000},
         {10'h21C, 10'h218, 10'h214, 10'h210, 10'h20C, 10'h208, 10'h204, 10'h200},
         {16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000});
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    p_done = done_cyc.size();
    acc_c = 0;
    x = 0;
    fork
      begin
        send(10'h300, 10'h010, 1'b0,
             {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000},
             {10'h370, 10'h360, 10'h350, 10'h340, 10'h330, 10'h320, 10'h310, 10'h300},
             {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000});
        acc_c = cyc;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("full_third_stalled", 32'(bus.in_ready), 32'd0);
        bus.wr_ready = 1'b1;
        x = cyc;
      end
    join
    chk("third_accept_cycle", 32'(acc_c),
        (done_cyc.size() > p_done) ? 32'(done_cyc[p_done] + 2) : 32'hFFFF_FFFF);
    wait_idle();
    chk("full_write_count", 32'(pop_cnt - p_pop), 32'd24);
    chk("full_no_bubble", 32'(last_pop_cyc), 32'(x + 23));
    chk("full_count", 32'(bus.bundle_count), 32'd5);

    // Address wrap
    send(10'h3F8, 10'h002, 1'b0,
         {16'h0808, 16'h0707, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101},
         {10'h006, 10'h004, 10'h002, 10'h000, 10'h3FE, 10'h3FC, 10'h3FA, 10'h3F8},
         {16'h0808, 16'h0707, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101});
    wait_idle();
    chk("wrap_count", 32'(bus.bundle_count), 32'd6);

    // Zero stride: all writes to the base address, in order
    send(10'h055, 10'h000, 1'b0,
         {16'h0F07, 16'h0F06, 16'h0F05, 16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00},
         {10'h055, 10'h055, 10'h055, 10'h055, 10'h055, 10'h055, 10'h055, 10'h055},
         {16'h0F07, 16'h0F06, 16'h0F05, 16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00});
    wait_idle();
    chk("stride0_count", 32'(bus.bundle_count), 32'd7);
    chk("stride0_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset during the 4th write
    send(10'h040, 10'h001, 1'b0,
         {16'hD007, 16'hD006, 16'hD005, 16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000},
         {10'h047, 10'h046, 10'h045, 10'h044, 10'h043, 10'h042, 10'h041, 10'h040},
         {16'hD007, 16'hD006, 16'hD005, 16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000});
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst4_addr_before", 32'(bus.wr_addr), 32'h043);
    rst_n = 1'b0;
    #1;
    chk("rst4_wr_en_async", 32'(bus.wr_en), 32'd0);
    chk("rst4_busy", 32'(bus.busy), 32'd0);
    chk("rst4_discarded", 32'(sb_q.size()), 32'd5);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst4_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst4_count", 32'(bus.bundle_count), 32'd0);
    p_pop = pop_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("rst4_no_writes", 32'(pop_cnt), 32'(p_pop));

    // INTT select: scaled only when the optional feature is built in
`ifdef RADIX8_WB_INTT_SCALE_EN
    scale_exp = {{7{16'h0000}}, 16'd7621};
`else
    scale_exp = {{7{16'h0000}}, 16'd2};
`endif
    send(10'h1C0, 10'h001, 1'b1, {{7{16'h0000}}, 16'd2},
         {10'h1C7, 10'h1C6, 10'h1C5, 10'h1C4, 10'h1C3, 10'h1C2, 10'h1C1, 10'h1C0},
         scale_exp);
    wait_idle();
    send(10'h1D0, 10'h001, 1'b0, {{7{16'h0000}}, 16'd2},
         {10'h1D7, 10'h1D6, 10'h1D5, 10'h1D4, 10'h1D3, 10'h1D2, 10'h1D1, 10'h1D0},
         {{7{16'h0000}}, 16'd2});
    wait_idle();
    chk("sel_count", 32'(bus.bundle_count), 32'd2);
    @(posedge clk); #1;
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
